sonic_enc_arbiter: RTL and testbench



---
 rtl/sonic_arb_pkg.sv | 18 +
 rtl/sonic_resp_fifo.sv | 50 +++++
 rtl/sonic_enc_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sonic_enc_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_arb_pkg.sv
// Shared types for the sonic_enc_arbiter front end: block/key widths,
// the {valid, id} tag carried alongside the encrypt core, and the request bundle.
package sonic_arb_pkg;

  localparam int BLK_W = 128;
  localparam int KEY_W = 256;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  typedef struct packed {
    logic [BLK_W-1:0] data;
    logic [KEY_W-1:0] key;
  } req_t;

endpackage

// File: rtl/sonic_resp_fifo.sv
// Per-requester response FIFO, first-word-fall-through. Output data reads 0
// while empty. Push and pop in the same cycle are both honoured; the
// arbiter's credits ensure a push never lands on a full FIFO without a pop.
module sonic_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         rd_ready,
  output logic         rd_valid,
  output logic [W-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic          pop;

  assign rd_valid = (wr_q != rd_q);
  assign pop      = rd_valid & rd_ready;
  assign rd_data  = rd_valid ? mem[rd_q[AW-1:0]] : '0;

  // Pointer advance; the extra MSB separates full from empty.
  always_comb begin
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sonic_enc_arbiter.sv
// Two-requester round-robin front end for the sonic_encrypt_128x256 core.
// Grants one request per cycle, drives the core input registers, tracks
// each in-flight block with a tag line and buffers results per requester.
// Optional SONIC_ARB_STATS_EN adds completed-response counters.
module sonic_enc_arbiter
  import sonic_arb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int CORE_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [BLK_W-1:0] req0_data,
  input  logic [KEY_W-1:0] req0_key,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [BLK_W-1:0] req1_data,
  input  logic [KEY_W-1:0] req1_key,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [BLK_W-1:0] resp0_data,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [BLK_W-1:0] resp1_data,
  output logic [BLK_W-1:0] core_in,
  output logic [KEY_W-1:0] core_key,
  output logic             core_valid,
  input  logic [BLK_W-1:0] core_out,
  input  logic             core_out_valid
`ifdef SONIC_ARB_STATS_EN
  ,
  output logic [31:0]      stat0_count,
  output logic [31:0]      stat1_count
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  req_t [1:0]             req;
  logic [1:0]             req_valid, elig, gnt, pop, push, resp_valid, resp_ready;
  logic [1:0][BLK_W-1:0]  resp_data;
  logic                   gnt_id;
  logic [1:0][CW-1:0]     credit_q, credit_d;
  logic                   ptr_q, ptr_d;
  logic [BLK_W-1:0]       core_in_q, core_in_d;
  logic [KEY_W-1:0]       core_key_q, core_key_d;
  logic                   core_valid_q, core_valid_d;
  tag_t [CORE_LAT:0]      tag_q, tag_d;
  tag_t                   head;

  assign req[0]     = '{data: req0_data, key: req0_key};
  assign req[1]     = '{data: req1_data, key: req1_key};
  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};
  assign pop        = resp_valid & resp_ready;
  assign gnt_id     = gnt[1];
  assign head       = tag_q[CORE_LAT];

  assign req0_ready  = gnt[0];
  assign req1_ready  = gnt[1];
  assign resp0_valid = resp_valid[0];
  assign resp1_valid = resp_valid[1];
  assign resp0_data  = resp_data[0];
  assign resp1_data  = resp_data[1];
  assign core_in     = core_in_q;
  assign core_key    = core_key_q;
  assign core_valid  = core_valid_q;

  // Round-robin grant; the pointer always moves to the requester not granted.
  always_comb begin
    elig  = '0;
    gnt   = '0;
    ptr_d = ptr_q;
    for (int i = 0; i < 2; i++)
      elig[i] = req_valid[i] && (credit_q[i] != '0) && !reset;
    if (elig == 2'b11) begin
      gnt[ptr_q] = 1'b1;
      ptr_d      = ~ptr_q;
    end else if (elig[0]) begin
      gnt   = 2'b01;
      ptr_d = 1'b1;
    end else if (elig[1]) begin
      gnt   = 2'b10;
      ptr_d = 1'b0;
    end
  end

  // Credits: a grant spends one, a pop returns one, both together cancel.
  always_comb begin
    credit_d = credit_q;
    for (int i = 0; i < 2; i++) begin
      if (gnt[i] && !pop[i])      credit_d[i] = credit_q[i] - CW'(1);
      else if (!gnt[i] && pop[i]) credit_d[i] = credit_q[i] + CW'(1);
    end
  end

  // Core input registers load on grant and hold otherwise; tag line shifts
  // every cycle with stage 0 aligned to core_valid.
  always_comb begin
    core_in_d    = core_in_q;
    core_key_d   = core_key_q;
    core_valid_d = |gnt;
    if (|gnt) begin
      core_in_d  = req[gnt_id].data;
      core_key_d = req[gnt_id].key;
    end
    tag_d    = tag_q;
    tag_d[0] = '{vld: |gnt, id: gnt_id};
    for (int k = 1; k <= CORE_LAT; k++) tag_d[k] = tag_q[k-1];
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_q     <= {2{CW'(DEPTH)}};
      ptr_q        <= 1'b0;
      core_in_q    <= '0;
      core_key_q   <= '0;
      core_valid_q <= 1'b0;
      tag_q        <= '0;
    end else begin
      credit_q     <= credit_d;
      ptr_q        <= ptr_d;
      core_in_q    <= core_in_d;
      core_key_q   <= core_key_d;
      core_valid_q <= core_valid_d;
      tag_q        <= tag_d;
    end
  end

  // Route each core result to the FIFO named by the tag head.
  assign push[0] = core_out_valid & head.vld & ~head.id;
  assign push[1] = core_out_valid & head.vld &  head.id;

  for (genvar i = 0; i < 2; i++) begin : g_fifo
    sonic_resp_fifo #(.DEPTH(DEPTH), .W(BLK_W)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[i]),
      .push_data (core_out),
      .rd_ready  (resp_ready[i]),
      .rd_valid  (resp_valid[i]),
      .rd_data   (resp_data[i])
    );
  end

`ifdef SONIC_ARB_STATS_EN
  logic [1:0][31:0] stat_q, stat_d;

  // Completed-response counters, wrapping at 2^32.
  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < 2; i++) stat_d[i] = stat_q[i] + 32'(pop[i]);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat0_count = stat_q[0];
  assign stat1_count = stat_q[1];
`endif

`ifndef SYNTHESIS
  a_no_orphan_result: assert property (@(posedge clk) disable iff (reset)
    core_out_valid |-> head.vld);
  a_no_lost_result: assert property (@(posedge clk) disable iff (reset)
    head.vld |-> core_out_valid);
`endif

endmodule

// File: tb/tb_sonic_enc_arbiter.sv
// Directed bench for sonic_enc_arbiter with a 2-cycle behavioural core model
// and per-port expected-response queues.
module tb_sonic_enc_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_data = '0, req1_data = '0;
  logic [255:0] req0_key = '0, req1_key = '0;
  logic         resp0_valid, resp1_valid;
  logic         resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [127:0] resp0_data, resp1_data;
  logic [127:0] core_in;
  logic [255:0] core_key;
  logic         core_valid;
  logic [127:0] core_out;
  logic         core_out_valid;
`ifdef SONIC_ARB_STATS_EN
  logic [31:0]  stat0_count, stat1_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int pops0 = 0, pops1 = 0;
  logic [127:0] q0[$];
  logic [127:0] q1[$];

  always #5 clk = ~clk;

  sonic_enc_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .core_in(core_in), .core_key(core_key), .core_valid(core_valid),
    .core_out(core_out), .core_out_valid(core_out_valid)
`ifdef SONIC_ARB_STATS_EN
    , .stat0_count(stat0_count), .stat1_count(stat1_count)
`endif
  );

  // Golden stand-in for the cipher: any fixed mixing function of data and key.
  function automatic logic [127:0] enc(input logic [127:0] d, input logic [255:0] k);
    return {d[62:0], d[127:63]} ^ k[127:0] ^ k[255:128] ^ 128'h0123456789abcdef_fedcba9876543210;
  endfunction

  // Behavioural core: fixed 2-cycle latency, cleared by reset.
  logic [1:0]   cm_v = '0;
  logic [127:0] cm_d0 = '0, cm_d1 = '0;
  always @(posedge clk) begin
    if (reset) cm_v <= '0;
    else begin
      cm_v  <= {cm_v[0], core_valid};
      cm_d0 <= enc(core_in, core_key);
      cm_d1 <= cm_d0;
    end
  end
  assign core_out       = cm_d1;
  assign core_out_valid = cm_v[1];

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    reset       = 1'b1;
    tick;
    tick;
    q0.delete();
    q1.delete();
    reset = 1'b0;
  endtask

  // Response scoreboard: every pop must match the next expected ciphertext.
  always @(negedge clk) begin
    if (!reset && resp0_valid && resp0_ready) begin
      if (q0.size() == 0) chk("resp0_unexpected", 256'(q0.size()), 256'(1));
      else begin
        chk("resp0_data", 256'(resp0_data), 256'(q0.pop_front()));
        pops0++;
      end
    end
    if (!reset && resp1_valid && resp1_ready) begin
      if (q1.size() == 0) chk("resp1_unexpected", 256'(q1.size()), 256'(1));
      else begin
        chk("resp1_data", 256'(resp1_data), 256'(q1.pop_front()));
        pops1++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int g, p0, p1;

    // Reset values, with a request pending to show ready is held low.
    reset = 1'b1;
    req0_valid = 1'b1;
    tick;
    tick;
    chk("rst_req0_ready", 256'(req0_ready), 256'(0));
    chk("rst_resp0_valid", 256'(resp0_valid), 256'(0));
    chk("rst_resp1_valid", 256'(resp1_valid), 256'(0));
    chk("rst_resp0_data", 256'(resp0_data), 256'(0));
    chk("rst_core_valid", 256'(core_valid), 256'(0));
    chk("rst_core_in", 256'(core_in), 256'(0));
    chk("rst_core_key", core_key, 256'(0));

    // Single request: data 0, key 0.
    reset = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    req0_data = '0;
    req0_key  = '0;
    #1;
    chk("single_gnt", 256'(req0_ready), 256'(1));
    q0.push_back(enc('0, '0));
    tick;                                   // cycle T+1
    req0_valid = 1'b0;
    chk("single_core_valid", 256'(core_valid), 256'(1));
    tick;
    chk("single_core_valid_drop", 256'(core_valid), 256'(0));
    tick;                                   // cycle T+3
    chk("single_resp_early", 256'(resp0_valid), 256'(0));
    tick;                                   // cycle T+4
    chk("single_resp_valid", 256'(resp0_valid), 256'(1));
    chk("single_resp_data", 256'(resp0_data), 256'(enc('0, '0)));
    chk("single_resp1_idle", 256'(resp1_valid), 256'(0));
    repeat (3) tick;

    // Contention: both valid for 8 cycles, grants must alternate from req0.
    do_reset;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    p0 = pops0;
    p1 = pops1;
    for (int c = 0; c < 8; c++) begin
      req0_data = 128'h1000 | 128'(c);
      req0_key  = {8{32'(c)}};
      req1_data = 128'h2000 | 128'(c);
      req1_key  = ~{8{32'(c)}};
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("rr_gnt0", 256'(req0_ready), 256'(c % 2 == 0));
      chk("rr_gnt1", 256'(req1_ready), 256'(c % 2 == 1));
      if (c % 2 == 0) q0.push_back(enc(req0_data, req0_key));
      else            q1.push_back(enc(req1_data, req1_key));
      tick;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (8) tick;
    chk("rr_count0", 256'(pops0 - p0), 256'(4));
    chk("rr_count1", 256'(pops1 - p1), 256'(4));

    // Credit exhaustion with a stalled consumer.
    do_reset;
    g = 0;
    for (int c = 0; c < 10; c++) begin
      req0_data  = 128'h3000 | 128'(c);
      req0_valid = 1'b1;
      #1;
      if (req0_ready) begin
        g++;
        q0.push_back(enc(req0_data, req0_key));
      end
      tick;
    end
    chk("cx_grants", 256'(g), 256'(4));
    chk("cx_stalled", 256'(req0_ready), 256'(0));
    chk("cx_fifo_full_valid", 256'(resp0_valid), 256'(1));
    resp0_ready = 1'b1;
    #1;
    chk("cx_pop_cycle_no_gnt", 256'(req0_ready), 256'(0));
    tick;
    resp0_ready = 1'b0;
    g = 0;
    for (int c = 0; c < 6; c++) begin
      req0_data = 128'h3100 | 128'(c);
      #1;
      if (req0_ready) begin
        g++;
        q0.push_back(enc(req0_data, req0_key));
      end
      tick;
    end
    chk("cx_one_more", 256'(g), 256'(1));
    req0_valid  = 1'b0;
    resp0_ready = 1'b1;
    repeat (8) tick;
    chk("cx_drained", 256'(q0.size()), 256'(0));

    // Grant and pop together at credit 1; push and pop together in the FIFO.
    do_reset;
    for (int c = 0; c < 3; c++) begin
      req0_data  = 128'h4000 | 128'(c);
      req0_valid = 1'b1;
      #1;
      chk("c1_fill_gnt", 256'(req0_ready), 256'(1));
      q0.push_back(enc(req0_data, req0_key));
      tick;
    end
    req0_valid = 1'b0;
    repeat (5) tick;
    req0_data   = 128'h4100;
    req0_valid  = 1'b1;
    resp0_ready = 1'b1;
    #1;
    chk("c1_gnt_with_pop", 256'(req0_ready), 256'(1));
    q0.push_back(enc(req0_data, req0_key));
    tick;
    req0_data   = 128'h4101;
    resp0_ready = 1'b0;
    #1;
    chk("c1_credit_kept", 256'(req0_ready), 256'(1));
    q0.push_back(enc(req0_data, req0_key));
    tick;
    #1;
    chk("c1_credit_spent", 256'(req0_ready), 256'(0));
    req0_valid  = 1'b0;
    tick;
    resp0_ready = 1'b1;                     // pop on the edge the first result is written
    tick;
    resp0_ready = 1'b0;
    tick;
    p0 = pops0;
    resp0_ready = 1'b1;
    repeat (6) tick;
    chk("c1_occupancy", 256'(pops0 - p0), 256'(3));
    chk("c1_drained", 256'(q0.size()), 256'(0));

    // Reset one cycle after two grants are in flight.
    do_reset;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mr_gnt_a", 256'(req0_ready), 256'(1));
    tick;
    #1;
    chk("mr_gnt_b", 256'(req1_ready), 256'(1));
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    q0.delete();
    q1.delete();
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("mr_no_resp", 256'({resp1_valid, resp0_valid}), 256'(0));
      tick;
    end
    resp0_ready = 1'b0;
    req0_data  = 128'h5000;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mr_first_req0", 256'({req1_ready, req0_ready}), 256'(1));
    q0.push_back(enc(req0_data, req0_key));
    tick;
    req1_valid = 1'b0;
    g = 1;
    for (int c = 0; c < 8; c++) begin
      req0_data = 128'h5001 + 128'(c);
      #1;
      if (req0_ready) begin
        g++;
        q0.push_back(enc(req0_data, req0_key));
      end
      tick;
    end
    chk("mr_credits", 256'(g), 256'(4));
    req0_valid  = 1'b0;
    resp0_ready = 1'b1;
    repeat (8) tick;
    chk("mr_drained", 256'(q0.size()), 256'(0));

`ifdef SONIC_ARB_STATS_EN
    // Ten completed responses on port 1 only.
    do_reset;
    resp1_ready = 1'b1;
    g = 0;
    for (int c = 0; c < 40 && g < 10; c++) begin
      req1_data  = 128'h6000 | 128'(c);
      req1_valid = 1'b1;
      #1;
      if (req1_ready) begin
        g++;
        q1.push_back(enc(req1_data, req1_key));
      end
      tick;
    end
    req1_valid = 1'b0;
    repeat (8) tick;
    chk("stat1_count", 256'(stat1_count), 256'(10));
    chk("stat0_count", 256'(stat0_count), 256'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
